// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and constants for the instruction-fetch path:
//                fetch FSM state encoding, PC-select codes and the ARM
//                pipeline offset applied to branch targets.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Fetch controller states; explicit 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_FULL  = 3'd2,
        ST_DROP  = 3'd3,
        ST_ERR   = 3'd4
    } fetch_state_e;

    // PC register input select codes
    localparam logic [1:0] PCS_SEQ = 2'b00;   // PC + 4
    localparam logic [1:0] PCS_BR  = 2'b01;   // branch target B
    localparam logic [1:0] PCS_JMP = 2'b10;   // register jump target F

    // The architectural PC reads two instructions ahead when a branch executes
    localparam logic [31:0] PIPE_OFS = 32'd8;

    // Branch target: PC + 8 + sign-extended word offset, wrapping at 32 bits
    function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                  input logic [23:0] imm24);
        return pc + PIPE_OFS + {{6{imm24[23]}}, imm24, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_unit_if
//  Description : Bus bundle of the fetch unit: instruction-memory req/ack
//                read channel and the instruction-register valid/ready
//                channel toward decode. The master side is the fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ifetch_unit_if;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] ir;
    logic        ir_valid;
    logic        ir_ready;

    modport master (
        output mem_req, mem_addr, ir, ir_valid,
        input  mem_ack, mem_rdata, ir_ready
    );

    modport slave (
        input  mem_req, mem_addr, ir, ir_valid,
        output mem_ack, mem_rdata, ir_ready
    );

endinterface
`default_nettype wire

// File: rtl/ifetch_unit_branch_target_gen.sv
`default_nettype none
// ============================================================================
//  Module      : branch_target_gen
//  Description : Combinational target generation for the PC register:
//                branch target from PC and the 24-bit immediate, jump target
//                from a register value forced to word alignment.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_target_gen
    import cpu_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [23:0] i_imm24,
    input  logic [29:0] i_rn_word,
    output logic [31:0] o_b,
    output logic [31:0] o_f
);

    // Both targets are pure functions of the current operands
    always_comb begin
        o_b = branch_target(i_pc, i_imm24);
        o_f = {i_rn_word, 2'b00};
    end

endmodule
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_unit
//  Description : Multi-cycle instruction-fetch controller. Fetches from
//                instruction memory at PC, holds the word in an instruction
//                register toward decode, and on handoff pulses Write_PC with
//                the PC-select and targets for the PC register. Supports
//                flush of held/in-flight instructions and a sticky fetch
//                timeout error.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic               clk,
    input  logic               Rst_n,
    input  logic [31:0]        PC,
    ifetch_unit_if.master      fbus,
    input  logic               take_b,
    input  logic               take_f,
    input  logic [31:0]        rn_data,
    input  logic               flush,
    output logic               Write_PC,
    output logic [1:0]         PC_s,
    output logic [31:0]        B,
    output logic [31:0]        F,
    output logic               fetch_err
);

    // Last count value still spent waiting in FETCH before giving up
    localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT - 1);

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;
    logic [TO_W-1:0]   r_cnt;
    logic [TO_W-1:0]   w_cnt_nxt;
    logic [31:0]       r_ir;
    logic              w_ir_load;
    logic              w_mem_req;
    logic              w_ir_valid;
    logic              w_write_pc;
    logic [1:0]        w_pc_s;
    logic [31:0]       w_b;
    logic [31:0]       w_f;
    logic              w_unused;

    // The jump target discards the byte-offset bits of the register value
    assign w_unused = ^rn_data[1:0];

    branch_target_gen u_tgt (
        .i_pc      (PC),
        .i_imm24   (r_ir[23:0]),
        .i_rn_word (rn_data[31:2]),
        .o_b       (w_b),
        .o_f       (w_f)
    );

    // State, timeout counter and instruction register
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_ir_load) begin
                r_ir <= fbus.mem_rdata;
            end
        end
    end

    // Next-state and Moore/Mealy outputs; the counter only runs in FETCH
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_ir_load   = 1'b0;
        w_mem_req   = 1'b0;
        w_ir_valid  = 1'b0;
        w_write_pc  = 1'b0;
        w_pc_s      = PCS_SEQ;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                w_mem_req = 1'b1;
                if (fbus.mem_ack) begin
                    // A flush landing on the ack discards the word and refetches
                    if (!flush) begin
                        w_ir_load   = 1'b1;
                        w_state_nxt = ST_FULL;
                    end
                end else if (flush) begin
                    w_state_nxt = ST_DROP;
                end else if (r_cnt == c_TO_LAST) begin
                    w_state_nxt = ST_ERR;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_FULL: begin
                w_ir_valid = 1'b1;
                // Flush has priority over a simultaneous handoff
                if (flush) begin
                    w_state_nxt = ST_FETCH;
                end else if (fbus.ir_ready) begin
                    w_write_pc  = 1'b1;
                    w_pc_s      = take_f ? PCS_JMP : (take_b ? PCS_BR : PCS_SEQ);
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_DROP: begin
                // Keep the request up until the orphaned response arrives
                w_mem_req = 1'b1;
                if (fbus.mem_ack) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_ERR: begin
                w_state_nxt = ST_ERR;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output drive; targets read as zero whenever no instruction is held
    always_comb begin
        fbus.mem_req  = w_mem_req;
        fbus.mem_addr = PC;
        fbus.ir       = r_ir;
        fbus.ir_valid = w_ir_valid;
        Write_PC      = w_write_pc;
        PC_s          = w_pc_s;
        B             = w_ir_valid ? w_b : 32'd0;
        F             = w_ir_valid ? w_f : 32'd0;
        fetch_err     = (r_state == ST_ERR);
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifetch_unit
//  Description : Self-checking bench for ifetch_unit. Models the PC register
//                (negedge update) and instruction memory, and predicts the
//                fetch address sequence from ARM branch/jump rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;

    logic        clk;
    logic        Rst_n;
    logic [31:0] PC;
    logic        take_b;
    logic        take_f;
    logic [31:0] rn_data;
    logic        flush;
    logic        Write_PC;
    logic [1:0]  PC_s;
    logic [31:0] B;
    logic [31:0] F;
    logic        fetch_err;

    int          n_cmp;
    int          n_fail;
    logic [31:0] exp_pc;

    ifetch_unit_if bus ();

    ifetch_unit #(.TIMEOUT(64), .TO_W(7)) dut (
        .clk       (clk),
        .Rst_n     (Rst_n),
        .PC        (PC),
        .fbus      (bus),
        .take_b    (take_b),
        .take_f    (take_f),
        .rn_data   (rn_data),
        .flush     (flush),
        .Write_PC  (Write_PC),
        .PC_s      (PC_s),
        .B         (B),
        .F         (F),
        .fetch_err (fetch_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PC register of the surrounding CPU: updates on the falling edge
    always @(negedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            PC <= 32'd0;
        end else if (Write_PC) begin
            case (PC_s)
                2'b01:   PC <= B;
                2'b10:   PC <= F;
                default: PC <= PC + 32'd4;
            endcase
        end
    end

    // Architectural next PC after an instruction is handed off
    function automatic logic [31:0] model_next_pc(input logic [31:0] pc, input logic [31:0] instr,
                                                  input logic tb, input logic tf, input logic [31:0] rn);
        logic signed [31:0] off;
        off = {{8{instr[23]}}, instr[23:0]};
        if (tf)      return rn & 32'hFFFF_FFFC;
        else if (tb) return pc + 32'd8 + 32'(off * 4);
        else         return pc + 32'd4;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_mem_req",   32'(bus.mem_req),  32'd0);
        chk("rst_ir",        bus.ir,            32'd0);
        chk("rst_ir_valid",  32'(bus.ir_valid), 32'd0);
        chk("rst_write_pc",  32'(Write_PC),     32'd0);
        chk("rst_pc_s",      32'(PC_s),         32'd0);
        chk("rst_b",         B,                 32'd0);
        chk("rst_f",         F,                 32'd0);
        chk("rst_fetch_err", 32'(fetch_err),    32'd0);
    endtask

    // Bounded wait for a memory request at the predicted address
    task automatic wait_req();
        int k;
        k = 0;
        while (bus.mem_req !== 1'b1 && k < 20) begin
            tick();
            settle();
            k++;
        end
        chk("req_seen", 32'(bus.mem_req), 32'd1);
        chk("req_addr", bus.mem_addr, exp_pc);
    endtask

    // Request seen, 'lat' idle cycles, then ack with data; ends in first FULL cycle
    task automatic load_ir(input int lat, input logic [31:0] data);
        wait_req();
        for (int i = 0; i < lat; i++) begin
            tick();
            settle();
            chk("req_hold",  32'(bus.mem_req), 32'd1);
            chk("addr_hold", bus.mem_addr, exp_pc);
            chk("wr_in_fetch", 32'(Write_PC), 32'd0);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = data;
        tick();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom;
    endtask

    // Full fetch/handoff transaction with 'rdy' cycles of decode backpressure
    task automatic fetch_txn(input int lat, input logic [31:0] data, input int rdy,
                             input logic tb, input logic tf, input logic [31:0] rn);
        logic [1:0] exp_s;
        load_ir(lat, data);
        for (int i = 0; i <= rdy; i++) begin
            if (i > 0) tick();
            bus.ir_ready = (i == rdy);
            take_b  = tb;
            take_f  = tf;
            rn_data = rn;
            settle();
            chk("ir_valid", 32'(bus.ir_valid), 32'd1);
            chk("ir_data",  bus.ir, data);
            chk("req_low_full", 32'(bus.mem_req), 32'd0);
            if (i < rdy) chk("wr_stall", 32'(Write_PC), 32'd0);
        end
        exp_s = tf ? 2'b10 : (tb ? 2'b01 : 2'b00);
        chk("wr_handoff", 32'(Write_PC), 32'd1);
        chk("pc_s", 32'(PC_s), 32'(exp_s));
        if (tf)      chk("f_tgt", F, rn & 32'hFFFF_FFFC);
        else if (tb) chk("b_tgt", B, model_next_pc(exp_pc, data, 1'b1, 1'b0, rn));
        exp_pc = model_next_pc(exp_pc, data, tb, tf, rn);
        tick();
        bus.ir_ready = 1'b0;
        take_b  = 1'b0;
        take_f  = 1'b0;
        rn_data = $urandom;
        settle();
        chk("wr_after", 32'(Write_PC), 32'd0);
        chk("valid_after", 32'(bus.ir_valid), 32'd0);
        chk("next_req", 32'(bus.mem_req), 32'd1);
        chk("next_addr", bus.mem_addr, exp_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        exp_pc = 32'd0;
        Rst_n  = 1'b0;
        take_b = 1'b0;
        take_f = 1'b0;
        rn_data = 32'd0;
        flush  = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
        bus.ir_ready  = 1'b0;

        // Reset state
        #12;
        chk_reset_vals();
        tick();
        Rst_n = 1'b1;
        settle();
        chk("idle_no_req", 32'(bus.mem_req), 32'd0);

        // Sequential fetch, ack on the 3rd request cycle
        fetch_txn(2, 32'hE3A01005, 0, 1'b0, 1'b0, 32'd0);
        // Jump to 0x100, then branch-to-self at 0x100
        fetch_txn(1, 32'hE12FFF10, 0, 1'b0, 1'b1, 32'h0000_0100);
        fetch_txn(0, 32'hEAFFFFFE, 0, 1'b1, 1'b0, 32'd0);
        // Jump wins over branch
        fetch_txn(1, 32'hEA000010, 0, 1'b1, 1'b1, 32'h0000_2003);
        // Backpressure
        fetch_txn(1, 32'hE0812003, 5, 1'b0, 1'b0, 32'd0);

        // Flush in FETCH, orphaned ack two cycles later
        flush = 1'b1;
        settle();
        chk("fl_req", 32'(bus.mem_req), 32'd1);
        tick();
        flush = 1'b0;
        settle();
        chk("drop_req",  32'(bus.mem_req), 32'd1);
        chk("drop_addr", bus.mem_addr, exp_pc);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEADBEEF;
        tick();
        bus.mem_ack = 1'b0;
        settle();
        chk("drop_valid", 32'(bus.ir_valid), 32'd0);
        chk("drop_wr",    32'(Write_PC), 32'd0);
        chk("refetch_req", 32'(bus.mem_req), 32'd1);
        chk("refetch_addr", bus.mem_addr, exp_pc);

        // Flush coinciding with ack
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        flush = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        flush = 1'b0;
        settle();
        chk("flack_valid", 32'(bus.ir_valid), 32'd0);
        chk("flack_addr",  bus.mem_addr, exp_pc);

        // Flush in FULL, then flush coinciding with handoff
        for (int j = 0; j < 2; j++) begin
            load_ir(0, 32'hE2800001);
            flush = 1'b1;
            bus.ir_ready = (j == 1);
            settle();
            chk("flfull_wr", 32'(Write_PC), 32'd0);
            tick();
            flush = 1'b0;
            bus.ir_ready = 1'b0;
            settle();
            chk("flfull_valid", 32'(bus.ir_valid), 32'd0);
            chk("flfull_addr",  bus.mem_addr, exp_pc);
        end

        // Randomized transactions against the PC model
        for (int n = 0; n < 20; n++) begin
            fetch_txn($urandom_range(0, 3), $urandom, $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        end

        // Timeout: 64 cycles in FETCH without ack
        for (int i = 0; i < 63; i++) tick();
        settle();
        chk("to_edge_err", 32'(fetch_err), 32'd0);
        chk("to_edge_req", 32'(bus.mem_req), 32'd1);
        tick();
        settle();
        chk("to_err", 32'(fetch_err), 32'd1);
        chk("to_req", 32'(bus.mem_req), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        settle();
        chk("err_sticky", 32'(fetch_err), 32'd1);

        // Reset in ERR, then fetch restarts from 0
        Rst_n = 1'b0;
        #1;
        chk_reset_vals();
        tick();
        Rst_n = 1'b1;
        exp_pc = 32'd0;
        fetch_txn(1, 32'hE1A00000, 1, 1'b0, 1'b0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
